// File: rtl/score_display_ctrl.sv
// Score-to-BCD converter (serial double-dabble) driving a 4-digit multiplexed
// 7-segment display with leading-zero blanking.
module score_display_ctrl #(
  parameter int REFRESH_DIV = 100000,
  parameter int SCORE_MAX   = 9999
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] inScore,
  input  logic        scoreValid,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcdOut,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int                CNT_W    = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [15:0]       SAT      = 16'(SCORE_MAX);

  // state | meaning
  // IDLE  | waiting for a request; SHIFT | one double-dabble step per cycle; DONE | bcdOut published, done pulsed
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state, state_nxt;
  logic [15:0] shift_reg, acc, acc_adj, pend_score, start_score, sat_score;
  logic [31:0] dd_next;
  logic [3:0]  iter;
  logic        pend, start;

  logic [CNT_W-1:0] refresh_cnt;
  logic [1:0]       digit_idx;
  logic [3:0]       nib;
  logic             blank;
  logic [6:0]       seg_nxt;

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'd0:    seg_of = 7'b1000000;
      4'd1:    seg_of = 7'b1111001;
      4'd2:    seg_of = 7'b0100100;
      4'd3:    seg_of = 7'b0110000;
      4'd4:    seg_of = 7'b0011001;
      4'd5:    seg_of = 7'b0010010;
      4'd6:    seg_of = 7'b0000010;
      4'd7:    seg_of = 7'b1111000;
      4'd8:    seg_of = 7'b0000000;
      4'd9:    seg_of = 7'b0010000;
      default: seg_of = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < 4; i++) begin
      if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
    dd_next     = {acc_adj, shift_reg} << 1;
    start       = (state == IDLE) && (scoreValid || pend);
    // a fresh request in IDLE is newer than anything left pending
    start_score = scoreValid ? inScore : pend_score;
    sat_score   = (start_score > SAT) ? SAT : start_score;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = SHIFT;
      SHIFT: begin
        busy = 1'b1;
        if (iter == 4'd15) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      shift_reg  <= '0;
      acc        <= '0;
      iter       <= '0;
      pend       <= 1'b0;
      pend_score <= '0;
      bcdOut     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) begin
          shift_reg <= sat_score;
          acc       <= '0;
          iter      <= '0;
        end
        SHIFT: begin
          acc       <= dd_next[31:16];
          shift_reg <= dd_next[15:0];
          iter      <= iter + 4'd1;
          if (iter == 4'd15) bcdOut <= dd_next[31:16];
        end
        default: ;
      endcase
      if (state != IDLE) begin
        if (scoreValid) begin
          pend       <= 1'b1;
          pend_score <= inScore;
        end
      end else if (start) begin
        pend <= 1'b0;
      end
    end
  end

  always_comb begin
    nib   = bcdOut[{digit_idx, 2'b00} +: 4];
    blank = 1'b0;
    case (digit_idx)
      2'd3:    blank = (bcdOut[15:12] == 4'd0);
      2'd2:    blank = (bcdOut[15:8] == 8'd0);
      2'd1:    blank = (bcdOut[15:4] == 12'd0);
      default: blank = 1'b0;
    endcase
    seg_nxt = blank ? 7'b1111111 : seg_of(nib);
  end

  // an and seg come from the same registered digit index so they switch together
  always_ff @(posedge CLK) begin
    if (RST) begin
      refresh_cnt <= '0;
      digit_idx   <= 2'd0;
      an          <= 4'b1110;
      seg         <= 7'b1000000;
    end else begin
      if (refresh_cnt == CNT_LAST) begin
        refresh_cnt <= '0;
        digit_idx   <= digit_idx + 2'd1;
      end else begin
        refresh_cnt <= refresh_cnt + 1'b1;
      end
      an  <= ~(4'b0001 << digit_idx);
      seg <= seg_nxt;
    end
  end

  assign dp = 1'b1;

endmodule
